// File: rtl/readback_data_split.sv
// Splits one captured readback word into 16-bit slices presented one at a time.
// Software steps through the slices with rising edges on pulse; a fresh load always restarts at slice 0.
module readback_data_split #(
    parameter int DATA_WIDTH = 50,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    input  logic                  pulse,
    output logic [15:0]           data_out,
    output logic [CNT_WIDTH-1:0]  word_idx,
    output logic                  valid,
    output logic                  done,
    output logic                  ovr
);

    localparam int NWORDS    = (DATA_WIDTH + 15) / 16;
    localparam int PAD_WIDTH = NWORDS * 16;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [PAD_WIDTH-1:0]   shadow;
    logic [PAD_WIDTH-1:0]   padded;
    logic                   pulse_q;
    logic                   adv;
    logic                   last;
    logic [CNT_WIDTH-1:0]   next_idx;
    logic [15:0]            next_word;
    logic [15:0]            words [NWORDS];

    assign padded   = PAD_WIDTH'(data_in);
    assign adv      = pulse & ~pulse_q;
    assign last     = (word_idx == CNT_WIDTH'(NWORDS - 1));
    assign next_idx = word_idx + CNT_WIDTH'(1);

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_words
            assign words[gi] = shadow[16*gi +: 16];
        end
    endgenerate

    // Only consulted when the current slice is not the last one, so next_idx is always in range.
    always_comb begin
        next_word = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (next_idx == CNT_WIDTH'(k))
                next_word = words[k];
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shadow   <= '0;
            data_out <= '0;
            word_idx <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            ovr      <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= pulse;
            done    <= 1'b0;
            if (load) begin
                // A load while slices are pending discards the advance and flags the overrun.
                shadow   <= padded;
                data_out <= padded[15:0];
                word_idx <= '0;
                valid    <= 1'b1;
                state    <= SEND;
                if (state == SEND)
                    ovr <= 1'b1;
            end else if (state == SEND && adv) begin
                if (last) begin
                    data_out <= '0;
                    word_idx <= '0;
                    valid    <= 1'b0;
                    done     <= 1'b1;
                    state    <= IDLE;
                end else begin
                    data_out <= next_word;
                    word_idx <= next_idx;
                end
            end
        end
    end

endmodule

// File: doc/readback_data_split.md
Name: readback_data_split

Overview:
- Readback-direction counterpart of the configuration word builder.
- Captures one DATA_WIDTH-bit readback word from the TM shift register read path.
- Presents the word 16 bits at a time to a 16-bit status register; software advances to the next word by writing the pulse register.
- Sits between the TM shift register read/write engine and the control interface's status/pulse registers.

Parameters:
DATA_WIDTH, 50, width of readback word from TM shift register
CNT_WIDTH, 8, width of internal word counter and word_idx output
(derived, not overridable) NWORDS = (DATA_WIDTH+15)/16; PAD_WIDTH = NWORDS*16

Ports:
clk_in  input  1  control clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset; one clock domain only
data_in  input  DATA_WIDTH  readback word from TM shift register
load  input  1  capture strobe: sample data_in at this clock edge
pulse  input  1  advance request from pulse_reg; edge-detected
data_out  output  16  current 16-bit word
word_idx  output  CNT_WIDTH  index of word on data_out (0 = least significant)
valid  output  1  data_out holds an unread word
done  output  1  single-cycle strobe: last word consumed
ovr  output  1  sticky: load arrived while words were still unread

Behaviour:
- Reset (async, immediate, also mid-operation): state=IDLE, shadow=0, data_out=0, word_idx=0, valid=0, done=0, ovr=0, pulse_q=0.
- Edge detect: pulse_q <= pulse every cycle; adv = pulse & ~pulse_q. A pulse held high for N cycles advances once only.
- Capture: shadow <= {zero pad, data_in}, PAD_WIDTH bits. Word k = shadow[16k+15:16k]. Padding bits read 0.
- State IDLE:
  - load=1: capture; next cycle data_out=word 0, word_idx=0, valid=1, go to SEND. Load-to-valid latency is 1 cycle.
  - adv in IDLE is ignored; no output change.
- State SEND:
  - adv with word_idx < NWORDS-1: next cycle word_idx+1, data_out=word (word_idx+1), valid stays 1.
  - adv with word_idx = NWORDS-1: next cycle valid=0, data_out=0, word_idx=0, done=1 for exactly one cycle, go to IDLE.
  - No adv: all outputs hold.
- load in SEND (with or without adv the same cycle, including on the last word): load wins. Recapture, word_idx=0, data_out=new word 0, valid=1, ovr<=1. The adv is discarded and done is not asserted.
- load and adv in the same cycle in IDLE: load taken, adv ignored.
- ovr is cleared only by rst.
- done is 0 in all cycles except the one after the last-word adv.
- NWORDS=1 (DATA_WIDTH<=16): the first adv after load ends the sequence.
- Counter: word_idx never exceeds NWORDS-1; no wrap-around beyond that. CNT_WIDTH must satisfy 2^CNT_WIDTH >= NWORDS.
- Suggested implementation uses registered outputs only, with a 2-state FSM plus a counter.

Test Plan:
1. Reset value check: assert rst for 2 cycles, then release → data_out=0, word_idx=0, valid=0, done=0, ovr=0. Then drive pulse alone → no change.
2. Full sequence (DATA_WIDTH=50): load one cycle with data_in=50'h3_9ABE_AB39_1234 → next cycle valid=1, data_out=16'h1234, idx=0. Then four 1-cycle pulses → data_out 16'hAB39, 16'h9ABE, 16'h0003; the fourth pulse gives valid=0, data_out=0, done high exactly one cycle, ovr=0.
3. Long pulse: after load, hold pulse high 5 cycles → exactly one advance (data_out=16'hAB39, idx=1).
4. Overrun: after load and one pulse (idx=1), load data_in=50'h0_0000_0000_BEEF in the same cycle as a pulse → next cycle data_out=16'hBEEF, idx=0, valid=1, ovr=1, done=0. ovr stays 1 after a subsequent full sequence.
5. Async reset mid-operation: during SEND at idx=2, assert rst between clock edges → all outputs zero immediately, before the next clk_in edge. After release, pulse has no effect until the next load.
6. Edge parameter: DATA_WIDTH=16, load 16'hA5A5 → data_out=16'hA5A5. One pulse → done=1, valid=0.
